// File: rtl/data_mem_responder.sv
// Data-memory responder: services one load or store at a time from a
// word-organised big-endian RAM, stalling the pipeline for LATENCY cycles.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  input  logic [1:0]  data_write_size_2DM,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  output logic [31:0] data_read_fDM,
  output logic        dm_stall,
  output logic        dm_error
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_op;      // 1 = store
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_mem [Depth];

  logic                  w_req;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_op;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [1:0]            w_size;
  logic [31:0]           w_off;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_rd_word;
  logic [5:0]            w_nbits;
  logic [4:0]            w_obits;
  logic [31:0]           w_data_al;
  logic [31:0]           w_mask;
  logic [31:0]           w_merged;

  assign w_req    = MemRead_2DM | MemWrite_2DM;
  assign w_accept = (r_state == StIdle) && w_req;

  // The accept cycle is itself a stall cycle, so WAIT lasts LATENCY-1 cycles and
  // finishes when the counter reaches 1; LATENCY==1 commits straight from IDLE.
  assign w_commit = ((r_state == StWait) && (r_cnt == 4'd1)) ||
                    ((LATENCY == 1) && w_accept);

  assign dm_stall = !RESET && (w_accept || (r_state == StWait));

  // Live request fields are only needed when committing from IDLE (LATENCY==1).
  assign w_op    = (r_state == StIdle) ? MemWrite_2DM        : r_op;
  assign w_addr  = (r_state == StIdle) ? data_address_2DM    : r_addr;
  assign w_wdata = (r_state == StIdle) ? data_write_2DM      : r_wdata;
  assign w_size  = (r_state == StIdle) ? data_write_size_2DM : r_size;

  // Range check and word index.
  assign w_off      = w_addr - BASE_ADDR;
  assign w_in_range = (w_addr >= BASE_ADDR) && ((w_off >> (ADDR_WIDTH + 2)) == 32'd0);
  assign w_idx      = w_off[ADDR_WIDTH+1:2];
  assign w_rd_word  = r_mem[w_idx];

  // Big-endian merge: left-justify the n data bytes to byte 0, then slide them
  // down to byte o; anything shifted past byte 3 falls off the bottom.
  assign w_nbits   = (w_size == 2'd0) ? 6'd32 : {1'b0, w_size, 3'b000};
  assign w_obits   = {w_addr[1:0], 3'b000};
  assign w_data_al = (w_wdata << (6'd32 - w_nbits)) >> w_obits;
  assign w_mask    = ~(32'hFFFF_FFFF >> w_nbits) >> w_obits;
  assign w_merged  = (w_rd_word & ~w_mask) | (w_data_al & w_mask);

  // Access FSM with registered read data and error pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_op    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'd0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      r_error <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_op    <= MemWrite_2DM;
            r_addr  <= data_address_2DM;
            r_wdata <= data_write_2DM;
            r_size  <= data_write_size_2DM;
            if (LATENCY == 1) begin
              r_cnt   <= 4'd0;
              r_state <= StDone;
            end else begin
              r_cnt   <= 4'(LATENCY - 1);
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
      if (w_commit) begin
        r_error <= !w_in_range;
        if (!w_op) begin
          r_rdata <= w_in_range ? w_rd_word : 32'hDEAD_BEEF;
        end
      end
    end
  end

  // RAM write port; contents survive reset, but a reset on the commit edge drops the store.
  always_ff @(posedge CLK) begin
    if (!RESET && w_commit && w_op && w_in_range) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign data_read_fDM = r_rdata;
  assign dm_error      = r_error;

endmodule
